// File: rtl/gol_pkg.sv
// Shared Game of Life constants and cell types, reused by the engine, the
// census monitor and the HDMI debug overlay.
//   GOL_CELLS   : cells written per full generation sweep (256x256 torus)
//   GOL_SPECIES : number of live species ids (1..7)
//   GOL_DEAD    : cell code for a dead cell
package gol_pkg;

    localparam int           GOL_CELLS   = 65536;
    localparam int           GOL_SPECIES = 7;
    localparam logic [3:0]   GOL_DEAD    = 4'd0;

    typedef logic [2:0] species_t;
    typedef logic [3:0] cell_t;

    // Codes 8..15 are not legal cell values.
    function automatic logic is_invalid(input cell_t c);
        return c[3];
    endfunction

endpackage

// File: rtl/gol_sat_counter.sv
// Saturating up-counter with a generation-restart input.
//   clk_i     : clock
//   rst_n_i   : asynchronous active-low reset
//   inc_i     : count one event this cycle
//   restart_i : start a new count; an event in the same cycle counts as 1
//   cnt_o     : current count, sticks at all-ones
module gol_sat_counter #(
    parameter int W = 17
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    input  logic         restart_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = inc_i ? ONE : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/gol_census.sv
// Passive census monitor on the Game of Life engine write stream.
// Counts live cells per species each generation, snapshots on a change of
// gen_count, and flags extinction, stagnation and malformed sweeps.
//   clk, rst_n    : pixel clock, asynchronous active-low reset
//   we, din       : engine write strobe and cell value being written
//   gen_count     : engine generation counter; any change is a boundary
//   rd_sel        : 0 = total alive, 1..7 = species count
//   rd_data       : registered snapshot count for rd_sel
//   snap_valid    : one-cycle pulse with the freshly latched snapshot
//   extinct       : last snapshot had no live cells
//   stagnant      : STALL_GENS consecutive identical snapshots
//   sweep_err     : sticky, a checked sweep had a bad write count or invalid codes
//   invalid_cnt   : invalid-code writes in the last snapshot
module gol_census
    import gol_pkg::*;
#(
    parameter int CELLS      = GOL_CELLS,
    parameter int CNT_W      = 17,
    parameter int STALL_GENS = 8,
    parameter int GEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  cell_t            din,
    input  logic [GEN_W-1:0] gen_count,
    input  species_t         rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             snap_valid,
    output logic             extinct,
    output logic             stagnant,
    output logic             sweep_err,
    output logic [CNT_W-1:0] invalid_cnt
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CELLS_C   = CNT_W'(CELLS);
    localparam int                 SUM_W     = CNT_W + 3;
    localparam int                 STALL_W   = $clog2(STALL_GENS + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_GENS);

    logic             boundary;
    logic [CNT_W-1:0] acc [1:GOL_SPECIES];
    logic [CNT_W-1:0] acc_inv;

    for (genvar g = 1; g <= GOL_SPECIES; g++) begin : g_species
        gol_sat_counter #(.W(CNT_W)) u_cnt (
            .clk_i     (clk),
            .rst_n_i   (rst_n),
            .inc_i     (we && (din == cell_t'(g))),
            .restart_i (boundary),
            .cnt_o     (acc[g])
        );
    end

    gol_sat_counter #(.W(CNT_W)) u_inv_cnt (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .inc_i     (we && is_invalid(din)),
        .restart_i (boundary),
        .cnt_o     (acc_inv)
    );

    // snap_q[0] holds the alive total so the read mux is a plain index.
    logic [CNT_W-1:0]   snap_q [0:GOL_SPECIES];
    logic [CNT_W-1:0]   snap_d [0:GOL_SPECIES];
    logic [GEN_W-1:0]   gen_prev_q;
    logic [CNT_W-1:0]   total_wr_q, total_wr_d;
    logic [CNT_W-1:0]   invalid_q, invalid_d;
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               snap_valid_q, snap_valid_d;
    logic               extinct_q, extinct_d;
    logic               stagnant_q, stagnant_d;
    logic               sweep_err_q, sweep_err_d;
    logic               first_snap_q, first_snap_d;
    logic [SUM_W-1:0]   sum_full;
    logic [CNT_W-1:0]   sum_sat;
    logic               same_snap;

    assign boundary = (gen_count != gen_prev_q);

    always_comb begin
        sum_full  = '0;
        same_snap = 1'b1;
        for (int i = 1; i <= GOL_SPECIES; i++) begin
            sum_full = sum_full + SUM_W'(acc[i]);
            if (acc[i] != snap_q[i]) same_snap = 1'b0;
        end
        // Saturated species counters can still sum past the counter range.
        sum_sat = (sum_full > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_full[CNT_W-1:0];
    end

    always_comb begin
        total_wr_d   = total_wr_q;
        snap_d       = snap_q;
        invalid_d    = invalid_q;
        stall_d      = stall_q;
        extinct_d    = extinct_q;
        stagnant_d   = stagnant_q;
        sweep_err_d  = sweep_err_q;
        first_snap_d = first_snap_q;
        snap_valid_d = boundary;
        rd_data_d    = snap_q[rd_sel];

        if (boundary) begin
            total_wr_d = we ? CNT_ONE : '0;
        end else if (we && (total_wr_q != CNT_MAX)) begin
            total_wr_d = total_wr_q + CNT_ONE;
        end

        if (boundary) begin
            snap_d[0] = sum_sat;
            for (int i = 1; i <= GOL_SPECIES; i++) snap_d[i] = acc[i];
            invalid_d = acc_inv;
            extinct_d = (sum_sat == '0);
            if (!same_snap)                stall_d = '0;
            else if (stall_q != STALL_MAX) stall_d = stall_q + 1'b1;
            stagnant_d = (stall_d == STALL_MAX);
            // The first boundary after reset closes the init/partial sweep.
            if (first_snap_q) begin
                first_snap_d = 1'b0;
            end else if ((total_wr_q != CELLS_C) || (acc_inv != '0)) begin
                sweep_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= GOL_SPECIES; i++) snap_q[i] <= '0;
            gen_prev_q   <= '0;
            total_wr_q   <= '0;
            invalid_q    <= '0;
            rd_data_q    <= '0;
            stall_q      <= '0;
            snap_valid_q <= 1'b0;
            extinct_q    <= 1'b0;
            stagnant_q   <= 1'b0;
            sweep_err_q  <= 1'b0;
            first_snap_q <= 1'b1;
        end else begin
            snap_q       <= snap_d;
            gen_prev_q   <= gen_count;
            total_wr_q   <= total_wr_d;
            invalid_q    <= invalid_d;
            rd_data_q    <= rd_data_d;
            stall_q      <= stall_d;
            snap_valid_q <= snap_valid_d;
            extinct_q    <= extinct_d;
            stagnant_q   <= stagnant_d;
            sweep_err_q  <= sweep_err_d;
            first_snap_q <= first_snap_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign snap_valid  = snap_valid_q;
    assign extinct     = extinct_q;
    assign stagnant    = stagnant_q;
    assign sweep_err   = sweep_err_q;
    assign invalid_cnt = invalid_q;

endmodule

// File: tb/tb_gol_census.sv
module tb_gol_census;

    localparam int CELLS = 64;
    localparam int CNT_W = 7;
    localparam int STALL = 8;
    localparam int GEN_W = 16;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             we = 1'b0;
    logic [3:0]       din = 4'd0;
    logic [GEN_W-1:0] gen_count = '0;
    logic [2:0]       rd_sel = 3'd0;
    logic [CNT_W-1:0] rd_data;
    logic             snap_valid, extinct, stagnant, sweep_err;
    logic [CNT_W-1:0] invalid_cnt;

    int total = 0;
    int bad = 0;

    // Reference model: per-generation write tallies and last snapshot.
    int m_cnt [16];
    int m_total;
    int m_snap [8];
    int m_inv;
    int m_stall;
    bit m_first, m_err, m_ext;

    gol_census #(.CELLS(CELLS), .CNT_W(CNT_W), .STALL_GENS(STALL), .GEN_W(GEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .din(din), .gen_count(gen_count),
        .rd_sel(rd_sel), .rd_data(rd_data), .snap_valid(snap_valid),
        .extinct(extinct), .stagnant(stagnant), .sweep_err(sweep_err),
        .invalid_cnt(invalid_cnt)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic logic [3:0] rand_cell(input bit allow_inv);
        if (allow_inv && ($urandom_range(0, 9) == 0)) return 4'(8 + $urandom_range(0, 7));
        return 4'($urandom_range(0, 7));
    endfunction

    task automatic clr_model();
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        for (int i = 0; i < 8; i++) m_snap[i] = 0;
        m_total = 0; m_inv = 0; m_stall = 0;
        m_first = 1; m_err = 0; m_ext = 0;
    endtask

    task automatic cyc(input bit w, input logic [3:0] d);
        we = w; din = d;
        @(posedge clk); #1;
        if (w) begin m_cnt[d]++; m_total++; end
    endtask

    task automatic fill(input int n, input bit allow_inv);
        int done = 0;
        while (done < n) begin
            if ($urandom_range(0, 3) == 0) cyc(0, 4'd0);
            else begin cyc(1, rand_cell(allow_inv)); done++; end
        end
    endtask

    task automatic check_zero(input string tag);
        total++; if (rd_data !== '0)     begin bad++; $display("FAIL %s rd_data got=%0d want=0", tag, rd_data); end
        total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL %s snap_valid got=%b want=0", tag, snap_valid); end
        total++; if (extinct !== 1'b0)    begin bad++; $display("FAIL %s extinct got=%b want=0", tag, extinct); end
        total++; if (stagnant !== 1'b0)   begin bad++; $display("FAIL %s stagnant got=%b want=0", tag, stagnant); end
        total++; if (sweep_err !== 1'b0)  begin bad++; $display("FAIL %s sweep_err got=%b want=0", tag, sweep_err); end
        total++; if (invalid_cnt !== '0)  begin bad++; $display("FAIL %s invalid_cnt got=%0d want=0", tag, invalid_cnt); end
    endtask

    // Change generation with an optional write in the same cycle; check the
    // flags of the new snapshot and that rd_data sampled then is still old.
    task automatic boundary(input logic [GEN_W-1:0] ng, input bit w, input logic [3:0] d);
        int  old_tot = m_snap[0];
        int  ns [8];
        int  inv = 0;
        bit  same = 1;
        gen_count = ng; we = w; din = d; rd_sel = 3'd0;
        @(posedge clk); #1;
        ns[0] = 0;
        for (int s = 1; s < 8; s++) begin ns[s] = sat(m_cnt[s]); ns[0] += ns[s]; end
        ns[0] = sat(ns[0]);
        for (int s = 8; s < 16; s++) inv += m_cnt[s];
        inv = sat(inv);
        for (int s = 1; s < 8; s++) if (ns[s] != m_snap[s]) same = 0;
        m_stall = same ? ((m_stall < STALL) ? m_stall + 1 : STALL) : 0;
        if (!m_first && ((sat(m_total) != CELLS) || (inv != 0))) m_err = 1;
        m_first = 0;
        for (int s = 0; s < 8; s++) m_snap[s] = ns[s];
        m_inv = inv; m_ext = (ns[0] == 0);
        for (int s = 0; s < 16; s++) m_cnt[s] = 0;
        m_total = 0;
        if (w) begin m_cnt[d] = 1; m_total = 1; end

        total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL snap_valid_pulse gen=%0d got=%b want=1", ng, snap_valid); end
        total++; if (rd_data !== CNT_W'(old_tot)) begin bad++; $display("FAIL rd_pre_update gen=%0d got=%0d want=%0d", ng, rd_data, old_tot); end
        total++; if (extinct !== m_ext) begin bad++; $display("FAIL extinct gen=%0d got=%b want=%b", ng, extinct, m_ext); end
        total++; if (stagnant !== (m_stall == STALL)) begin bad++; $display("FAIL stagnant gen=%0d got=%b want=%b", ng, stagnant, m_stall == STALL); end
        total++; if (sweep_err !== m_err) begin bad++; $display("FAIL sweep_err gen=%0d got=%b want=%b", ng, sweep_err, m_err); end
        total++; if (invalid_cnt !== CNT_W'(m_inv)) begin bad++; $display("FAIL invalid_cnt gen=%0d got=%0d want=%0d", ng, invalid_cnt, m_inv); end
        cyc(0, 4'd0);
        total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL snap_valid_single gen=%0d got=%b want=0", ng, snap_valid); end
    endtask

    task automatic check_reads(input string tag);
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            cyc(0, 4'd0);
            total++;
            if (rd_data !== CNT_W'(m_snap[s])) begin
                bad++; $display("FAIL %s rd_sel=%0d got=%0d want=%0d", tag, s, rd_data, m_snap[s]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gen_count = '0; we = 0; rd_sel = 0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        clr_model();
    endtask

    task automatic test_first_sweep();
        for (int i = 0; i < CELLS; i++) cyc(1, 4'd3);
        boundary(16'd1, 0, 4'd0);
        check_reads("first_sweep");
    endtask

    task automatic test_mixed();
        for (int i = 0; i < 10; i++) cyc(1, 4'd1);
        for (int i = 0; i < 20; i++) cyc(1, 4'd7);
        for (int i = 0; i < CELLS - 30; i++) cyc(1, 4'd0);
        boundary(16'd2, 0, 4'd0);
        check_reads("mixed");
    endtask

    task automatic test_stagnation();
        for (int k = 0; k < STALL + 2; k++) begin
            for (int i = 0; i < CELLS; i++) cyc(1, 4'd0);
            boundary(16'(3 + k), 0, 4'd0);
        end
        for (int i = 0; i < CELLS - 1; i++) cyc(1, 4'd0);
        cyc(1, 4'd2);
        boundary(16'd20, 0, 4'd0);
        check_reads("stagnation");
    endtask

    task automatic test_sweep_err();
        fill(CELLS - 2, 0);
        cyc(1, 4'd9);
        boundary(16'd21, 0, 4'd0);
        for (int k = 0; k < 2; k++) begin
            fill(CELLS, 0);
            boundary(16'(22 + k), 0, 4'd0);
        end
        check_reads("sweep_err");
    endtask

    task automatic test_back_to_back_write();
        fill(CELLS, 0);
        boundary(16'd30, 1, 4'd5);
        fill(CELLS - 1, 0);
        boundary(16'd31, 0, 4'd0);
        check_reads("boundary_write");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < MAXV + 30; i++) cyc(1, 4'd4);
        boundary(16'd40, 0, 4'd0);
        check_reads("saturation");
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            fill(($urandom_range(0, 2) == 0) ? CELLS + 1 - $urandom_range(0, 2) : CELLS, 1);
            boundary(16'(50 + k), 1'($urandom_range(0, 1)), rand_cell(1));
            check_reads("random");
        end
    endtask

    task automatic test_wrap();
        fill(CELLS, 0);
        boundary(16'hFFFF, 0, 4'd0);
        for (int i = 0; i < CELLS; i++) cyc(1, 4'd6);
        boundary(16'h0000, 0, 4'd0);
        check_reads("wrap");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 20; i++) cyc(1, 4'd1);
        #2 rst_n = 1'b0; gen_count = '0; we = 0;
        #1 check_zero("async_reset");
        @(negedge clk); rst_n = 1'b1;
        clr_model();
        for (int i = 0; i < 10; i++) cyc(1, 4'd9);
        boundary(16'd1, 0, 4'd0);
        for (int i = 0; i < 5; i++) cyc(1, 4'd1);
        boundary(16'd2, 0, 4'd0);
        check_reads("reset_mid");
    endtask

    initial begin
        clr_model();
        test_reset();
        test_first_sweep();
        test_mixed();
        test_stagnation();
        test_sweep_err();
        test_back_to_back_write();
        test_saturation();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
